ofmap_pool_stream: RTL and testbench

- Downstream neighbour of the convolution stage.
- Captures one full OFMAP_SIZE x OFMAP_SIZE result matrix from the convolution array through a valid/ready handshake.
- Performs non-overlapping POOL_SIZE x POOL_SIZE max-pooling on the captured frame, requantizes each pooled value by a right shift with saturation back to IP_DATA_WIDTH, and streams the results in raster order.
- The output stream feeds the next layer's ifmap loader.

---
 rtl/ofmap_pool_stream.sv | 122 ++++++++++++
 tb/tb_ofmap_pool_stream.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_pool_stream.sv
// Single-buffered max-pool stage: captures one convolution result frame, then streams
// POOL_SIZE x POOL_SIZE max-pooled, shift-requantized, saturated samples in raster order.
module ofmap_pool_stream #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int OFMAP_SIZE    = 4,
    parameter int POOL_SIZE     = 2,
    parameter int SHIFT         = 0,
    localparam int RES_WIDTH    = 2*IP_DATA_WIDTH + 1,
    localparam int POOL_OUT     = OFMAP_SIZE / POOL_SIZE,
    localparam int IDX_W        = (POOL_OUT > 1) ? $clog2(POOL_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RES_WIDTH-1:0]     result_matrix [OFMAP_SIZE][OFMAP_SIZE],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IP_DATA_WIDTH-1:0] out_data,
    output logic                     out_last,
    output logic [IDX_W-1:0]         out_row,
    output logic [IDX_W-1:0]         out_col
);

    localparam int AW = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(POOL_OUT - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t state, state_next;

    logic [RES_WIDTH-1:0]     fbuf [OFMAP_SIZE][OFMAP_SIZE];
    logic [RES_WIDTH-1:0]     src  [OFMAP_SIZE][OFMAP_SIZE];
    logic [IDX_W-1:0]         row, col, nrow, ncol;
    logic [AW-1:0]            ri, ci;
    logic [RES_WIDTH-1:0]     win_max, win_q;
    logic [IP_DATA_WIDTH-1:0] win_data;
    logic                     capture, fire, at_last;

    assign at_last = (row == LAST) && (col == LAST);
    assign capture = in_valid && in_ready;
    assign fire    = out_valid && out_ready;
    assign out_row = row;
    assign out_col = col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = EMIT;
            EMIT:    if (out_ready && at_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == EMIT);
        out_last  = (state == EMIT) && at_last;
    end

    // Window for the next sample: (0,0) at capture, otherwise raster successor of (row,col).
    always_comb begin
        nrow = row;
        ncol = col + IDX_W'(1);
        if (state == IDLE) begin
            nrow = '0;
            ncol = '0;
        end else if (col == LAST) begin
            nrow = row + IDX_W'(1);
            ncol = '0;
        end
    end

    // At the capture edge the window must come straight from the input, the buffer is not loaded yet.
    always_comb begin
        if (state == IDLE) src = result_matrix;
        else               src = fbuf;
        win_max = '0;
        ri      = '0;
        ci      = '0;
        for (int unsigned i = 0; i < POOL_SIZE; i++) begin
            for (int unsigned j = 0; j < POOL_SIZE; j++) begin
                ri = AW'(int'(nrow) * POOL_SIZE + int'(i));
                ci = AW'(int'(ncol) * POOL_SIZE + int'(j));
                if (src[ri][ci] > win_max) win_max = src[ri][ci];
            end
        end
        win_q    = win_max >> SHIFT;
        win_data = (|(win_q >> IP_DATA_WIDTH)) ? '1 : win_q[IP_DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < OFMAP_SIZE; i++)
                for (int unsigned j = 0; j < OFMAP_SIZE; j++)
                    fbuf[i][j] <= '0;
            row      <= '0;
            col      <= '0;
            out_data <= '0;
        end else if (capture) begin
            fbuf     <= result_matrix;
            row      <= '0;
            col      <= '0;
            out_data <= win_data;
        end else if (fire) begin
            if (at_last) begin
                row <= '0;
                col <= '0;
            end else begin
                row      <= nrow;
                col      <= ncol;
                out_data <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_ofmap_pool_stream.sv
// Self-checking bench: two instances (SHIFT=0 and SHIFT=2) share stimulus and are
// compared against an arithmetic max-pool/requantize reference.
module tb_ofmap_pool_stream;

    localparam int IW = 8;
    localparam int N  = 4;
    localparam int P  = 2;
    localparam int RW = 2*IW + 1;
    localparam int PO = N / P;
    localparam int NS = PO * PO;

    typedef logic [RW-1:0] frame_t [N][N];

    logic     clk = 0;
    logic     rst_n = 0;
    logic     in_valid = 0;
    logic     out_ready = 0;
    frame_t   rm;
    logic     in_ready0, in_ready2, out_valid0, out_valid2, out_last0, out_last2;
    logic [IW-1:0] d0, d2;
    logic [0:0] r0, c0, r2, c2;

    int checks = 0;
    int errors = 0;

    ofmap_pool_stream #(.IP_DATA_WIDTH(IW), .OFMAP_SIZE(N), .POOL_SIZE(P), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .result_matrix(rm), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(d0), .out_last(out_last0), .out_row(r0), .out_col(c0)
    );

    ofmap_pool_stream #(.IP_DATA_WIDTH(IW), .OFMAP_SIZE(N), .POOL_SIZE(P), .SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .result_matrix(rm), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(d2), .out_last(out_last2), .out_row(r2), .out_col(c2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model(input frame_t f, input int r, input int c, input int sh);
        int unsigned m = 0;
        for (int i = 0; i < P; i++)
            for (int j = 0; j < P; j++)
                if (int'(f[r*P+i][c*P+j]) > int'(m)) m = f[r*P+i][c*P+j];
        m = m >> sh;
        return (m > (1 << IW) - 1) ? (1 << IW) - 1 : m;
    endfunction

    function automatic frame_t rand_frame(input int kind);
        frame_t f;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                case (kind)
                    0:       f[i][j] = RW'($urandom);
                    1:       f[i][j] = RW'($urandom_range(0, 31));
                    default: f[i][j] = RW'($urandom_range(0, 2000));
                endcase
        return f;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_in_ready0"}, in_ready0, 1);
        check({tag, "_in_ready2"}, in_ready2, 1);
        check({tag, "_out_valid0"}, out_valid0, 0);
        check({tag, "_out_valid2"}, out_valid2, 0);
        check({tag, "_out_last0"}, out_last0, 0);
        check({tag, "_out_last2"}, out_last2, 0);
    endtask

    task automatic check_reset(input string tag);
        check_idle(tag);
        check({tag, "_data0"}, d0, 0);
        check({tag, "_data2"}, d2, 0);
        check({tag, "_row0"}, r0, 0);
        check({tag, "_col0"}, c0, 0);
    endtask

    // Called #1 after a rising edge; the capture happens at the next edge.
    task automatic capture(input frame_t f);
        rm       = f;
        in_valid = 1;
        check("cap_in_ready0", in_ready0, 1);
        check("cap_in_ready2", in_ready2, 1);
        @(posedge clk); #1;
    endtask

    // mode 0: always ready, 1: random ready, 2: three stall cycles on the second sample.
    task automatic emit(input frame_t f, input int mode, input int nsamp, input bit busy, input frame_t nxt);
        int k = 0;
        int cyc = 0;
        int stall = 0;
        bit rdy;
        if (busy) begin
            rm       = nxt;
            in_valid = 1;
        end else begin
            in_valid = 0;
            rm       = rand_frame(0);
        end
        while (k < nsamp && cyc < 64) begin
            case (mode)
                0:       rdy = 1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: begin
                    rdy = !(k == 1 && stall < 3);
                    if (!rdy) stall++;
                end
            endcase
            out_ready = rdy;
            check("out_valid0", out_valid0, 1);
            check("out_valid2", out_valid2, 1);
            check("in_ready_busy0", in_ready0, 0);
            check("in_ready_busy2", in_ready2, 0);
            check("data_s0", d0, model(f, k / PO, k % PO, 0));
            check("data_s2", d2, model(f, k / PO, k % PO, 2));
            check("row0", r0, k / PO);
            check("col0", c0, k % PO);
            check("row2", r2, k / PO);
            check("col2", c2, k % PO);
            check("last0", out_last0, (k == NS - 1));
            check("last2", out_last2, (k == NS - 1));
            @(posedge clk); #1;
            if (rdy) k++;
            cyc++;
        end
        check("samples_accepted", k, nsamp);
        if (nsamp == NS) check_idle("post_frame");
    endtask

    initial begin
        frame_t basic, sat, zeros, sevens, fa, fr, dummy;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                basic[i][j]  = RW'(i*N + j + 1);
                sat[i][j]    = '1;
                zeros[i][j]  = '0;
                sevens[i][j] = RW'($urandom_range(0, 6));
                dummy[i][j]  = '0;
            end
        for (int i = 0; i < P; i++)
            for (int j = 0; j < P; j++)
                sevens[P+i][j] = RW'(7);

        rst_n = 0;
        #12;
        check_reset("reset");
        rst_n = 1;
        @(posedge clk); #1;

        capture(basic);
        emit(basic, 0, NS, 0, dummy);

        capture(sat);
        emit(sat, 0, NS, 0, dummy);

        capture(basic);
        emit(basic, 2, NS, 0, dummy);

        fa = rand_frame(2);
        capture(fa);
        emit(fa, 0, NS, 1, basic);
        capture(basic);
        emit(basic, 1, NS, 0, dummy);

        capture(zeros);
        emit(zeros, 0, NS, 0, dummy);
        capture(sevens);
        emit(sevens, 1, NS, 0, dummy);

        capture(basic);
        emit(basic, 0, 2, 0, dummy);
        #2 rst_n = 0;
        #1 check_reset("mid_reset");
        rst_n = 1;
        @(posedge clk); #1;
        check_idle("after_reset");
        fr = rand_frame(2);
        capture(fr);
        emit(fr, 0, NS, 0, dummy);

        for (int t = 0; t < 20; t++) begin
            fr = rand_frame(t % 3);
            capture(fr);
            emit(fr, 1, NS, 0, dummy);
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 0;
                @(posedge clk); #1;
                check_idle("gap");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
